// File: rtl/intra_pred_rowgen_pkg.sv
// Shared types and constants for the VP8/WebP row-streaming intra predictor.
package intra_pred_rowgen_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_DC = 2'd0,
    MODE_TM = 2'd1,
    MODE_V  = 2'd2,
    MODE_H  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // DC value used when neither edge is available: mid-grey.
  function automatic int unsigned dc_fill(input int unsigned bw);
    return 32'd1 << (bw - 1);
  endfunction

endpackage

// File: rtl/intra_pred_rowgen_row.sv
// One predicted row from captured edges: N TrueMotion clip lanes plus
// the DC/V/H pass-through selection.
module intra_pred_rowgen_row
  import intra_pred_rowgen_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [MODE_W-1:0]            mode_i,
  input  logic [BIT_WIDTH-1:0]         dc_i,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] top_i,
  input  logic [BIT_WIDTH-1:0]         left_i,
  input  logic [BIT_WIDTH-1:0]         top_left_i,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0] row_o
);

  localparam int N  = BLOCK_SIZE;
  localparam int IW = BIT_WIDTH + 2;

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [BIT_WIDTH-1:0]  top_px;
    logic signed [IW-1:0]  t;
    logic [BIT_WIDTH-1:0]  clip;
    logic [BIT_WIDTH-1:0]  px;

    assign top_px = top_i[g*BIT_WIDTH +: BIT_WIDTH];
    assign t = $signed({2'b00, top_px})
             + $signed({2'b00, left_i})
             - $signed({2'b00, top_left_i});

    // Sign bit -> below zero; bit BIT_WIDTH set on a positive value -> above max.
    always_comb begin
      if (t[IW-1]) begin
        clip = '0;
      end else if (t[BIT_WIDTH]) begin
        clip = '1;
      end else begin
        clip = t[BIT_WIDTH-1:0];
      end
    end

    always_comb begin
      px = '0;
      unique case (mode_i)
        MODE_DC: px = dc_i;
        MODE_TM: px = clip;
        MODE_V:  px = top_px;
        MODE_H:  px = left_i;
        default: px = '0;
      endcase
    end

    assign row_o[g*BIT_WIDTH +: BIT_WIDTH] = px;
  end

endmodule

// File: rtl/intra_pred_rowgen.sv
// Intra predictor top: edge capture handshake, DC adder tree, row counter
// and the IDLE/EMIT controller streaming one predicted row per cycle.
module intra_pred_rowgen
  import intra_pred_rowgen_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      mode,
  input  logic                            top_avail,
  input  logic                            left_avail,
  input  logic [BIT_WIDTH-1:0]            top_left,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] top,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] left,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0] out_row,
  output logic [$clog2(BLOCK_SIZE)-1:0]   out_row_idx,
  output logic                            out_last
);

  localparam int N     = BLOCK_SIZE;
  localparam int RW    = $clog2(N);
  localparam int SH1   = $clog2(N);
  localparam int SH2   = $clog2(2 * N);
  localparam int ACC_W = BIT_WIDTH + SH2;
  localparam int PW    = BIT_WIDTH * N;
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  state_e               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [PW-1:0]        top_q, left_q;
  logic [BIT_WIDTH-1:0] tl_q, dc_q, dc_d;
  logic [MODE_W-1:0]    mode_q;
  logic [ACC_W-1:0]     sum_t, sum_l, dc_acc;
  logic                 cap, take;

  assign cap  = in_valid & in_ready;
  assign take = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cap) state_d = ST_EMIT;
      ST_EMIT: if (take && out_last) state_d = cap ? ST_EMIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid   = (state_q == ST_EMIT);
    out_last    = out_valid && (row_q == LAST);
    out_row_idx = row_q;
    in_ready    = (state_q == ST_IDLE) || (out_valid && out_ready && out_last);
  end

  // DC rounding: both edges -> /2N, one edge -> /N, none -> mid-grey.
  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int i = 0; i < N; i++) begin
      sum_t = sum_t + ACC_W'(top[i*BIT_WIDTH +: BIT_WIDTH]);
      sum_l = sum_l + ACC_W'(left[i*BIT_WIDTH +: BIT_WIDTH]);
    end
    dc_acc = '0;
    unique case ({top_avail, left_avail})
      2'b11:   dc_acc = (sum_t + sum_l + ACC_W'(N)) >> SH2;
      2'b10:   dc_acc = (sum_t + ACC_W'(N / 2)) >> SH1;
      2'b01:   dc_acc = (sum_l + ACC_W'(N / 2)) >> SH1;
      default: dc_acc = ACC_W'(dc_fill(BIT_WIDTH));
    endcase
    dc_d = dc_acc[BIT_WIDTH-1:0];
  end

  always_comb begin
    row_d = row_q;
    if (cap) begin
      row_d = '0;
    end else if (take) begin
      row_d = out_last ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      top_q  <= '0;
      left_q <= '0;
      tl_q   <= '0;
      dc_q   <= '0;
      mode_q <= '0;
    end else begin
      row_q <= row_d;
      if (cap) begin
        top_q  <= top;
        left_q <= left;
        tl_q   <= top_left;
        dc_q   <= dc_d;
        mode_q <= mode;
      end
    end
  end

  intra_pred_rowgen_row #(
    .BIT_WIDTH  (BIT_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_row (
    .mode_i     (mode_q),
    .dc_i       (dc_q),
    .top_i      (top_q),
    .left_i     (left_q[row_q*BIT_WIDTH +: BIT_WIDTH]),
    .top_left_i (tl_q),
    .row_o      (out_row)
  );

endmodule

// File: tb/tb_intra_pred_rowgen.sv
// Scoreboard bench for intra_pred_rowgen at N=4 and N=16.
module tb_intra_pred_rowgen;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic         top_avail, left_avail;
  logic [7:0]   top_left;
  logic [127:0] top, left;

  logic         iv4, ir4, ov4, ol4;
  logic         or4 = 1'b1;
  logic [31:0]  row4;
  logic [1:0]   idx4;
  logic         iv16, ir16, ov16, ol16;
  logic         or16 = 1'b1;
  logic [127:0] row16;
  logic [3:0]   idx16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] q4_row[$];
  int           q4_idx[$];
  logic [127:0] q16_row[$];
  int           q16_idx[$];

  bit bp_en = 0;
  int bp_k = 0;
  bit last_acc;

  always #5 clk = ~clk;

  intra_pred_rowgen #(.BIT_WIDTH(8), .BLOCK_SIZE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .mode(mode),
    .top_avail(top_avail), .left_avail(left_avail), .top_left(top_left),
    .top(top[31:0]), .left(left[31:0]), .out_valid(ov4), .out_ready(or4),
    .out_row(row4), .out_row_idx(idx4), .out_last(ol4)
  );

  intra_pred_rowgen #(.BIT_WIDTH(8), .BLOCK_SIZE(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .mode(mode),
    .top_avail(top_avail), .left_avail(left_avail), .top_left(top_left),
    .top(top), .left(left), .out_valid(ov16), .out_ready(or16),
    .out_row(row16), .out_row_idx(idx16), .out_last(ol16)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pk4(input int a, input int b, input int c, input int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0];
    return {96'd0, d8, c8, b8, a8};
  endfunction

  function automatic logic [127:0] fill16(input int v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = v[7:0];
    return r;
  endfunction

  task automatic push4(input logic [127:0] r, input int i);
    q4_row.push_back(r);
    q4_idx.push_back(i);
  endtask

  task automatic push16(input logic [127:0] r, input int i);
    q16_row.push_back(r);
    q16_idx.push_back(i);
  endtask

  // Monitor for the N=4 instance: pops on every transfer, checks hold during stalls.
  logic [31:0] h4_row;
  logic [1:0]  h4_idx;
  bit          h4_v = 0;
  always @(negedge clk) begin
    logic [127:0] er;
    int ei;
    if (rst) begin
      h4_v = 0;
    end else begin
      if (h4_v) begin
        chk("hold4_valid", ov4, 1'b1);
        chk("hold4_row", row4, h4_row);
        chk("hold4_idx", idx4, h4_idx);
      end
      if (ov4 && or4) begin
        if (q4_row.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_row4: got idx %0d, expected no row", idx4);
        end else begin
          er = q4_row.pop_front();
          ei = q4_idx.pop_front();
          chk("row4", row4, er);
          chk("idx4", idx4, ei);
          chk("last4", ol4, ei == 3);
        end
      end
      h4_v   = ov4 && !or4;
      h4_row = row4;
      h4_idx = idx4;
    end
  end

  always @(negedge clk) begin
    logic [127:0] er;
    int ei;
    if (!rst && ov16 && or16) begin
      if (q16_row.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_row16: got idx %0d, expected no row", idx16);
      end else begin
        er = q16_row.pop_front();
        ei = q16_idx.pop_front();
        chk("row16", row16, er);
        chk("idx16", idx16, ei);
        chk("last16", ol16, ei == 15);
      end
    end
  end

  // out_ready pattern 1,0,0,1 repeating when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        or4 = (bp_k % 4 == 0) || (bp_k % 4 == 3);
        bp_k++;
      end else begin
        or4 = 1'b1;
      end
    end
  end

  task automatic send(input bit big, input logic [1:0] m, input logic ta,
                      input logic la, input logic [7:0] tl,
                      input logic [127:0] t, input logic [127:0] l);
    int k;
    mode = m; top_avail = ta; left_avail = la; top_left = tl; top = t; left = l;
    if (big) iv16 = 1'b1; else iv4 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(big ? ir16 : ir4) && k < 300);
    if (!(big ? ir16 : ir4)) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready still low after %0d cycles", k);
    end
    last_acc = big ? (ov16 && ol16 && or16) : (ov4 && ol4 && or4);
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    iv16 = 1'b0;
    chk("first_row_valid", big ? ov16 : ov4, 1'b1);
    chk("first_row_idx", big ? 128'(idx16) : 128'(idx4), 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q4_row.size() != 0 || q16_row.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("drain4", q4_row.size(), 0);
    chk("drain16", q16_row.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ramp;
    int k;
    rst = 1'b1; iv4 = 1'b0; iv16 = 1'b0; mode = '0;
    top_avail = 1'b0; left_avail = 1'b0; top_left = '0; top = '0; left = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov4", ov4, 1'b0);
    chk("rst_ir4", ir4, 1'b1);
    chk("rst_last4", ol4, 1'b0);
    chk("rst_idx4", idx4, 0);
    chk("rst_row4", row4, 0);
    chk("rst_ov16", ov16, 1'b0);
    chk("rst_ir16", ir16, 1'b1);
    chk("rst_row16", row16, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // TrueMotion with clipping at both ends.
    push4(pk4(0, 0, 110, 160), 0);
    push4(pk4(40, 50, 190, 240), 1);
    push4(pk4(130, 140, 255, 255), 2);
    push4(pk4(205, 215, 255, 255), 3);
    send(0, 2'd1, 0, 0, 8'd100, pk4(50, 60, 200, 250), pk4(10, 90, 180, 255));
    drain();

    // DC variants.
    for (int j = 0; j < 4; j++) push4(pk4(15, 15, 15, 15), j);
    send(0, 2'd0, 1, 1, 8'd0, pk4(10, 10, 10, 10), pk4(20, 20, 20, 20));
    for (int j = 0; j < 4; j++) push4(pk4(3, 3, 3, 3), j);
    send(0, 2'd0, 1, 0, 8'd77, pk4(1, 2, 3, 4), pk4(200, 200, 200, 200));
    for (int j = 0; j < 4; j++) push4(pk4(191, 191, 191, 191), j);
    send(0, 2'd0, 0, 1, 8'd0, pk4(9, 9, 9, 9), pk4(255, 255, 255, 0));
    for (int j = 0; j < 4; j++) push4(pk4(128, 128, 128, 128), j);
    send(0, 2'd0, 0, 0, 8'd5, pk4(1, 1, 1, 1), pk4(2, 2, 2, 2));
    drain();

    // V and H at N=16.
    for (int i = 0; i < 16; i++) ramp[i*8 +: 8] = 8'(i);
    for (int j = 0; j < 16; j++) push16(ramp, j);
    send(1, 2'd2, 0, 0, 8'd0, ramp, ramp << 4);
    for (int j = 0; j < 16; j++) push16(fill16(16 * j), j);
    for (int i = 0; i < 16; i++) left[i*8 +: 8] = 8'(16 * i);
    send(1, 2'd3, 0, 0, 8'd0, ramp, left);
    drain();

    // Backpressure on N=4.
    bp_en = 1;
    push4(pk4(7, 8, 9, 10), 0);
    push4(pk4(7, 8, 9, 10), 1);
    push4(pk4(7, 8, 9, 10), 2);
    push4(pk4(7, 8, 9, 10), 3);
    send(0, 2'd2, 0, 0, 8'd0, pk4(7, 8, 9, 10), pk4(0, 0, 0, 0));
    drain();
    bp_en = 0;
    @(posedge clk);
    #1;

    // Back-to-back: H block then V block held on in_valid.
    for (int j = 0; j < 4; j++) push4(pk4(j + 1, j + 1, j + 1, j + 1), j);
    for (int j = 0; j < 4; j++) push4(pk4(9, 8, 7, 6), j);
    send(0, 2'd3, 0, 0, 8'd0, pk4(0, 0, 0, 0), pk4(1, 2, 3, 4));
    send(0, 2'd2, 0, 0, 8'd0, pk4(9, 8, 7, 6), pk4(50, 50, 50, 50));
    chk("b2b_accept_on_last", last_acc, 1'b1);
    drain();

    // Reset in the middle of a block.
    for (int j = 0; j < 4; j++) push4(pk4(1, 2, 3, 4), j);
    send(0, 2'd2, 0, 0, 8'd0, pk4(1, 2, 3, 4), pk4(0, 0, 0, 0));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(ov4 && or4 && idx4 == 2'd1) && k < 20);
    chk("mid_row1_seen", idx4, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov4", ov4, 1'b0);
    chk("mid_rst_ir4", ir4, 1'b1);
    chk("mid_rst_idx4", idx4, 0);
    q4_row.delete();
    q4_idx.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push4(pk4(11, 22, 33, 44), 0);
    push4(pk4(11, 22, 33, 44), 1);
    push4(pk4(11, 22, 33, 44), 2);
    push4(pk4(11, 22, 33, 44), 3);
    send(0, 2'd2, 0, 0, 8'd0, pk4(11, 22, 33, 44), pk4(0, 0, 0, 0));
    drain();
    chk("end_idle4", ov4, 1'b0);
    chk("end_idle16", ov16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
